// File: rtl/root3_share_sched_if.sv
// Handshake bundle for the shared cube-root scheduler: input triple, output triple, core link.
// Latency: none (wiring only).
// Backpressure: valid/ready on both triple streams; the core link has no flow control.
//
// Ports of modport master (scheduler side):
//   in:  in_valid, in_a/b/c, out_ready, core_y
//   out: in_ready, out_valid, out_a/b/c, core_x
// Modport slave is the mirror image (source/sink/core side).
interface root3_share_sched_if #(
  parameter int DSIZE = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_a;
  logic [DSIZE-1:0] in_b;
  logic [DSIZE-1:0] in_c;
  logic [DSIZE-1:0] core_x;
  logic [DSIZE-1:0] core_y;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out_a;
  logic [DSIZE-1:0] out_b;
  logic [DSIZE-1:0] out_c;

  modport master (
    input  in_valid, in_a, in_b, in_c, core_y, out_ready,
    output in_ready, core_x, out_valid, out_a, out_b, out_c
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, core_y, out_ready,
    input  in_ready, core_x, out_valid, out_a, out_b, out_c
  );
endinterface

// File: rtl/root3_share_sched.sv
// Shares one free-running LAT-cycle cube-root core across the three channels of a pixel.
// Latency: accept in cycle T -> out_valid in cycle T+LAT+4 when the output register is free.
// Backpressure: at most 2 triples in flight (output register + collector); in_ready drops
//   until a pop, combinationally re-opened by out_valid & out_ready.
//
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   io_bus        : root3_share_sched_if.master (input triple, output triple, core_x/core_y)
//   o_done_cnt    : saturating completed-triple counter, only when ROOT3_SCHED_CNT_EN is defined
// Optional feature macro: ROOT3_SCHED_CNT_EN
module root3_share_sched #(
  parameter int DSIZE = 16,
  parameter int LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  root3_share_sched_if.master   io_bus
`ifdef ROOT3_SCHED_CNT_EN
  ,
  output logic [15:0]           o_done_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISS_A, ISS_B, ISS_C} state_t;

  typedef struct packed {
    logic       tv;
    logic [1:0] idx;
  } tag_t;

  state_t           r_state;
  logic [DSIZE-1:0] r_b;
  logic [DSIZE-1:0] r_c;
  logic [DSIZE-1:0] r_core_x;
  tag_t             r_tag [LAT];
  logic [1:0]       r_cred;
  logic [DSIZE-1:0] r_coll_a;
  logic [DSIZE-1:0] r_coll_b;
  logic [DSIZE-1:0] r_coll_c;
  logic             r_coll_full;
  logic             r_out_valid;
  logic [DSIZE-1:0] r_out_a;
  logic [DSIZE-1:0] r_out_b;
  logic [DSIZE-1:0] r_out_c;

  logic w_in_ready;
  logic w_hs_in;
  logic w_hs_out;
  tag_t w_tag_in;
  tag_t w_tag_out;

  assign w_hs_out   = r_out_valid & io_bus.out_ready;
  // Popping this cycle frees a credit, so a new triple may enter in the same cycle.
  assign w_in_ready = ((r_state == IDLE) || (r_state == ISS_C)) &&
                      ((r_cred < 2'd2) || w_hs_out) && !rst;
  assign w_hs_in    = io_bus.in_valid & w_in_ready;
  assign w_tag_out  = r_tag[LAT-1];

  // Tag entering the pipe describes the sample currently on core_x.
  always_comb begin
    w_tag_in = '0;
    case (r_state)
      ISS_A:   w_tag_in = '{tv: 1'b1, idx: 2'd0};
      ISS_B:   w_tag_in = '{tv: 1'b1, idx: 2'd1};
      ISS_C:   w_tag_in = '{tv: 1'b1, idx: 2'd2};
      default: w_tag_in = '0;
    endcase
  end

  // Issue FSM; core_x is registered alongside the next state so it matches the state it is in.
  // Channel a goes straight from the input to core_x, so only b and c need holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_b      <= '0;
      r_c      <= '0;
      r_core_x <= '0;
    end else begin
      case (r_state)
        IDLE, ISS_C: begin
          if (w_hs_in) begin
            r_state  <= ISS_A;
            r_b      <= io_bus.in_b;
            r_c      <= io_bus.in_c;
            r_core_x <= io_bus.in_a;
          end else begin
            r_state  <= IDLE;
            r_core_x <= '0;
          end
        end
        ISS_A: begin
          r_state  <= ISS_B;
          r_core_x <= r_b;
        end
        ISS_B: begin
          r_state  <= ISS_C;
          r_core_x <= r_c;
        end
      endcase
    end
  end

  // Tag pipe mirrors the core latency so each core_y arrives with its channel index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cred <= '0;
    end else begin
      case ({w_hs_in, w_hs_out})
        2'b10:   r_cred <= r_cred + 2'd1;
        2'b01:   r_cred <= r_cred - 2'd1;
        default: r_cred <= r_cred;
      endcase
    end
  end

  // Collector and output register. The credit limit guarantees a completion never
  // meets a full collector, so completion and collector drain are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll_a    <= '0;
      r_coll_b    <= '0;
      r_coll_c    <= '0;
      r_coll_full <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_c     <= '0;
    end else begin
      if (w_tag_out.tv && (w_tag_out.idx == 2'd0)) r_coll_a <= io_bus.core_y;
      if (w_tag_out.tv && (w_tag_out.idx == 2'd1)) r_coll_b <= io_bus.core_y;

      if (w_tag_out.tv && (w_tag_out.idx == 2'd2)) begin
        if (!r_out_valid || w_hs_out) begin
          // Slot c bypasses the collector so the output loads with no bubble.
          r_out_valid <= 1'b1;
          r_out_a     <= r_coll_a;
          r_out_b     <= r_coll_b;
          r_out_c     <= io_bus.core_y;
        end else begin
          r_coll_c    <= io_bus.core_y;
          r_coll_full <= 1'b1;
        end
      end else if (w_hs_out) begin
        if (r_coll_full) begin
          r_out_a     <= r_coll_a;
          r_out_b     <= r_coll_b;
          r_out_c     <= r_coll_c;
          r_coll_full <= 1'b0;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.core_x    = r_core_x;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_a     = r_out_a;
  assign io_bus.out_b     = r_out_b;
  assign io_bus.out_c     = r_out_c;

`ifdef ROOT3_SCHED_CNT_EN
  logic [15:0] r_done_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (w_hs_out && (r_done_cnt != 16'hFFFF)) begin
      r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  assign o_done_cnt = r_done_cnt;
`endif

endmodule

// File: tb/tb_root3_share_sched.sv
// Bench for root3_share_sched: XOR core model, queue-based reference of accepted triples.
// Latency: checks the T+7 output timing at LAT=3 in isolated transactions.
// Backpressure: exercises stalls, pop/completion overlap, reset mid-flight, random traffic.
module tb_root3_share_sched;
  localparam logic [15:0] K = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  root3_share_sched_if #(.DSIZE(16)) bus();

`ifdef ROOT3_SCHED_CNT_EN
  logic [15:0] done_cnt;
`endif

  root3_share_sched #(.DSIZE(16), .LAT(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
`ifdef ROOT3_SCHED_CNT_EN
    ,
    .o_done_cnt (done_cnt)
`endif
  );

  // Core model: y = x ^ 5A5A, three cycles after x.
  logic [15:0] cpipe [3] = '{default: 16'h0};
  always @(posedge clk) begin
    cpipe[0] <= bus.core_x;
    cpipe[1] <= cpipe[0];
    cpipe[2] <= cpipe[1];
  end
  assign bus.core_y = cpipe[2] ^ K;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = -100;
  int pops     = 0;
  logic [47:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] xf(input logic [47:0] t);
    return t ^ {K, K, K};
  endfunction

  function automatic logic [47:0] rnd3();
    logic [47:0] t;
    t[15:0]  = 16'($urandom);
    t[31:16] = 16'($urandom);
    t[47:32] = 16'($urandom);
    return t;
  endfunction

  // Reference model: every accepted triple must come out, in order, transformed per channel.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_acc = -100;
      pops     = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
        else chk("out_triple", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, exp_q.pop_front()});
        pops++;
      end
      // A new triple can only be taken once all three channels of the previous one issued.
      if (bus.in_ready) chk("in_ready_gap", 64'((cyc - last_acc) >= 3), 64'd1);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(xf({bus.in_a, bus.in_b, bus.in_c}));
        last_acc = cyc;
      end
    end
  end

  task automatic drive(input logic [47:0] t);
    {bus.in_a, bus.in_b, bus.in_c} = t;
  endtask

  task automatic wait_acc(input string tag, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!(bus.in_valid && bus.in_ready) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(bus.in_valid && bus.in_ready), 64'd1);
    t = cyc;
  endtask

  task automatic drain(input string tag);
    int k;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic single_timing(input string tag, input logic [47:0] t);
    int t0;
    @(posedge clk); #1;
    drive(t);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    wait_acc({tag, "_acc"}, t0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(k == 7));
      if (k == 7) chk({tag, "_out_data"}, {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(t)});
    end
  endtask

  initial begin
    int t0, ta, tb, tr, nacc, idx;
    logic [47:0] st [10];
    logic [47:0] bp [4];
    logic [47:0] sa, sb;

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    drive(48'h0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_core_x", 64'(bus.core_x), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Single triple with exact core_x and output timing
    @(posedge clk); #1;
    drive({16'h1000, 16'h2000, 16'h3000});
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    wait_acc("single_acc", t0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("single_out_valid", 64'(bus.out_valid), 64'(k == 7));
      if (k == 1) chk("single_core_x_a", 64'(bus.core_x), 64'h1000);
      if (k == 2) chk("single_core_x_b", 64'(bus.core_x), 64'h2000);
      if (k == 3) chk("single_core_x_c", 64'(bus.core_x), 64'h3000);
      if (k == 7) begin
        chk("single_out_a", 64'(bus.out_a), 64'h4A5A);
        chk("single_out_b", 64'(bus.out_b), 64'h7A5A);
        chk("single_out_c", 64'(bus.out_c), 64'h6A5A);
      end
    end

    // Streaming: in_valid held, out_ready high; accepts spaced 3 or 4 cycles by the credit limit
    for (int i = 0; i < 10; i++) st[i] = rnd3();
    @(posedge clk); #1;
    drive(st[0]);
    bus.in_valid = 1'b1;
    ta = -1;
    for (int i = 0; i < 10; i++) begin
      wait_acc("stream_acc", t0);
      if (i > 0) chk("stream_gap", 64'((t0 - ta) >= 3 && (t0 - ta) <= 4), 64'd1);
      ta = t0;
      @(posedge clk); #1;
      if (i < 9) drive(st[i+1]);
      else bus.in_valid = 1'b0;
    end
    drain("stream_drain");

    // Backpressure: only two triples fit while the sink stalls
    for (int i = 0; i < 4; i++) bp[i] = rnd3();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(bp[0]);
    nacc = 0;
    idx  = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) nacc++;
      @(posedge clk); #1;
      if (nacc > idx) begin
        idx = nacc;
        if (idx < 4) drive(bp[idx]);
        else bus.in_valid = 1'b0;
      end
    end
    chk("bp_accepts", 64'(nacc), 64'd2);
    @(negedge clk);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_data", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(bp[0])});
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_pop_data", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(bp[0])});
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_next_data", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(bp[1])});
    drain("bp_drain");

    // Pop coincides with completion of the second triple
    sa = rnd3();
    sb = rnd3();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(sa);
    wait_acc("sim_acc_a", ta);
    @(posedge clk); #1;
    drive(sb);
    wait_acc("sim_acc_b", tb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (cyc < tb + 6) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("sim_valid_pop", 64'(bus.out_valid), 64'd1);
    chk("sim_data_a", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(sa)});
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("sim_valid_next", 64'(bus.out_valid), 64'd1);
    chk("sim_data_b", {16'h0, bus.out_a, bus.out_b, bus.out_c}, {16'h0, xf(sb)});
    drain("sim_drain");

    // Reset two cycles after an accept
    @(posedge clk); #1;
    drive(rnd3());
    bus.in_valid = 1'b1;
    wait_acc("rst_mid_acc", tr);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_core_x", 64'(bus.core_x), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    single_timing("rst_new", rnd3());
`ifdef ROOT3_SCHED_CNT_EN
    @(posedge clk); #1;
    chk("cnt_after_rst", 64'(done_cnt), 64'(pops));
`endif

    // Random traffic against the reference queue
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive(rnd3());
    end
    drain("rand_drain");

`ifdef ROOT3_SCHED_CNT_EN
    @(posedge clk); #1;
    chk("cnt_total", 64'(done_cnt), 64'(pops));
    force dut.r_done_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_done_cnt;
    for (int i = 0; i < 3; i++) single_timing("cnt_sat", rnd3());
    drain("cnt_drain");
    @(posedge clk); #1;
    chk("cnt_saturate", 64'(done_cnt), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
